// File: rtl/usb4_enc_pkg.sv
// Shared constants and helpers for the USB4 Tx lane encoder:
// generation encodings, symbol lengths, sync headers and symbol assembly.
package usb4_enc_pkg;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned SYM_W  = 132;
  localparam int unsigned DATA_W = 128;

  typedef enum logic [1:0] {
    GEN4     = 2'b00,
    GEN3     = 2'b01,
    GEN2     = 2'b10,
    GEN_RSVD = 2'b11
  } gen_e;

  localparam int unsigned SYM_LEN_66  = 8;
  localparam int unsigned SYM_LEN_132 = 16;

  localparam logic [1:0] HDR66_DATA  = 2'b01;
  localparam logic [1:0] HDR66_OS    = 2'b10;
  localparam logic [3:0] HDR132_DATA = 4'b0101;
  localparam logic [3:0] HDR132_OS   = 4'b1010;

  // Index of the last byte of a symbol for the given generation.
  function automatic logic [3:0] last_idx(gen_e gen);
    logic [3:0] idx;
    if (gen == GEN2) idx = 4'(SYM_LEN_66 - 1);
    else             idx = 4'(SYM_LEN_132 - 1);
    return idx;
  endfunction

  // Wrap collected payload bytes (byte k at [8k +: 8]) into the output symbol.
  function automatic logic [SYM_W-1:0] build_symbol(gen_e gen, logic os,
                                                    logic [DATA_W-1:0] data);
    logic [SYM_W-1:0] sym;
    sym = '0;
    case (gen)
      GEN2:    sym[65:0] = {data[63:0], (os ? HDR66_OS : HDR66_DATA)};
      GEN3:    sym       = {data, (os ? HDR132_OS : HDR132_DATA)};
      default: sym       = {4'h0, data};
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/encoding_block_if.sv
// Lane byte input / encoded symbol output bundle of the Tx encoder.
// master = lane-distribution side, slave = encoder.
interface encoding_block_if #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned SYM_W  = 132
);

  logic              enable_enc;
  logic [1:0]        gen_speed;
  logic              data_os;
  logic [LANE_W-1:0] lane_0_tx;
  logic [LANE_W-1:0] lane_1_tx;
  logic [SYM_W-1:0]  lane_0_tx_enc;
  logic [SYM_W-1:0]  lane_1_tx_enc;
  logic              enc_valid;
  logic              sym_is_os;

  modport master (
    output enable_enc, gen_speed, data_os, lane_0_tx, lane_1_tx,
    input  lane_0_tx_enc, lane_1_tx_enc, enc_valid, sym_is_os
  );

  modport slave (
    input  enable_enc, gen_speed, data_os, lane_0_tx, lane_1_tx,
    output lane_0_tx_enc, lane_1_tx_enc, enc_valid, sym_is_os
  );

endinterface

// File: rtl/enc_lane_packer.sv
// Per-lane byte collector: inserts each accepted byte at its slot and, on
// the last byte of a symbol, registers the header-framed symbol.
module enc_lane_packer
  import usb4_enc_pkg::*;
(
  input  logic              enc_clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              last,
  input  logic [3:0]        byte_cnt,
  input  gen_e              sym_gen,
  input  logic              sym_os,
  input  logic [LANE_W-1:0] lane_byte,
  output logic [SYM_W-1:0]  tx_enc
);

  logic [DATA_W-1:0] ins_q;
  logic [DATA_W-1:0] ins_d;

  // Insert the current byte; byte 0 starts from a clean buffer so leftovers
  // of a discarded or longer previous symbol never leak into this one.
  always_comb begin
    ins_d = (byte_cnt == '0) ? '0 : ins_q;
    ins_d[{byte_cnt, 3'b000} +: LANE_W] = lane_byte;
  end

  // Buffer update and output register; the symbol is formed from ins_d so
  // the final byte lands in the output in the same edge it is accepted.
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      ins_q  <= '0;
      tx_enc <= '0;
    end else if (accept) begin
      ins_q <= ins_d;
      if (last) tx_enc <= build_symbol(sym_gen, sym_os, ins_d);
    end
  end

endmodule

// File: rtl/encoding_block.sv
// USB4 Tx encoder: packs two lock-step lane byte streams into 64b/66b (GEN2),
// 128b/132b (GEN3) or raw 128-bit (GEN4) symbols. Holds the shared byte
// counter, the per-symbol generation/OS latch and the enc_valid strobe.
module encoding_block
  import usb4_enc_pkg::*;
(
  input logic             enc_clk,
  input logic             rst,
  encoding_block_if.slave bus
);

  logic [3:0] byte_cnt;
  gen_e       gen_q;
  logic       os_q;
  logic       enc_valid_q;
  logic       sym_is_os_q;

  logic       sym_start;
  gen_e       sym_gen;
  logic       sym_os;
  logic       accept;
  logic       last;

  // Control for this cycle: at a symbol boundary the live gen/os inputs
  // apply, otherwise the values latched on that symbol's first byte.
  always_comb begin
    sym_start = (byte_cnt == '0);
    sym_gen   = sym_start ? gen_e'(bus.gen_speed) : gen_q;
    sym_os    = sym_start ? bus.data_os : os_q;
    accept    = bus.enable_enc && (sym_gen != GEN_RSVD);
    last      = accept && (byte_cnt == last_idx(sym_gen));
  end

  // Byte counter, per-symbol control latch and completion strobe.
  always_ff @(posedge enc_clk) begin
    if (rst) begin
      byte_cnt    <= '0;
      gen_q       <= GEN4;
      os_q        <= 1'b0;
      enc_valid_q <= 1'b0;
      sym_is_os_q <= 1'b0;
    end else begin
      enc_valid_q <= last;
      if (!accept) begin
        byte_cnt <= '0;
      end else begin
        if (sym_start) begin
          gen_q <= sym_gen;
          os_q  <= sym_os;
        end
        byte_cnt <= last ? '0 : byte_cnt + 4'd1;
        if (last) sym_is_os_q <= sym_os;
      end
    end
  end

  assign bus.enc_valid = enc_valid_q;
  assign bus.sym_is_os = sym_is_os_q;

  enc_lane_packer u_lane0 (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .accept    (accept),
    .last      (last),
    .byte_cnt  (byte_cnt),
    .sym_gen   (sym_gen),
    .sym_os    (sym_os),
    .lane_byte (bus.lane_0_tx),
    .tx_enc    (bus.lane_0_tx_enc)
  );

  enc_lane_packer u_lane1 (
    .enc_clk   (enc_clk),
    .rst       (rst),
    .accept    (accept),
    .last      (last),
    .byte_cnt  (byte_cnt),
    .sym_gen   (sym_gen),
    .sym_os    (sym_os),
    .lane_byte (bus.lane_1_tx),
    .tx_enc    (bus.lane_1_tx_enc)
  );

endmodule

// File: tb/tb_encoding_block.sv
// Bench for encoding_block: directed lane byte streams, a queue-based
// reference model checked every cycle, plus literal spot checks.
module tb_encoding_block;

  logic enc_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 enc_clk = ~enc_clk;

  encoding_block_if bus ();

  encoding_block dut (
    .enc_clk (enc_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: collect bytes per symbol, frame once the symbol is full.
  logic [7:0]   q0[$];
  logic [7:0]   q1[$];
  int           m_gen = 0;
  bit           m_os  = 1'b0;
  logic [131:0] exp0 = '0;
  logic [131:0] exp1 = '0;
  logic         exp_valid = 1'b0;
  logic         exp_os = 1'b0;

  always @(posedge enc_clk) begin
    bit acc;
    int len;
    int off;
    exp_valid = 1'b0;
    if (rst) begin
      q0.delete(); q1.delete();
      exp0 = '0; exp1 = '0; exp_os = 1'b0;
    end else if (!bus.enable_enc) begin
      q0.delete(); q1.delete();
    end else begin
      acc = 1'b1;
      if (q0.size() == 0) begin
        if (bus.gen_speed == 2'b11) acc = 1'b0;
        else begin
          m_gen = int'(bus.gen_speed);
          m_os  = bus.data_os;
        end
      end
      if (acc) begin
        q0.push_back(bus.lane_0_tx);
        q1.push_back(bus.lane_1_tx);
        len = (m_gen == 2) ? 8 : 16;
        if (q0.size() == len) begin
          off  = (m_gen == 2) ? 2 : ((m_gen == 1) ? 4 : 0);
          exp0 = '0;
          exp1 = '0;
          for (int k = 0; k < len; k++) begin
            exp0[off + 8*k +: 8] = q0[k];
            exp1[off + 8*k +: 8] = q1[k];
          end
          if (m_gen == 2) begin
            exp0[1:0] = m_os ? 2'b10 : 2'b01;
            exp1[1:0] = m_os ? 2'b10 : 2'b01;
          end else if (m_gen == 1) begin
            exp0[3:0] = m_os ? 4'b1010 : 4'b0101;
            exp1[3:0] = m_os ? 4'b1010 : 4'b0101;
          end
          exp_os    = m_os;
          exp_valid = 1'b1;
          q0.delete(); q1.delete();
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge enc_clk) begin
    if (cmp_on) begin
      chk("enc_valid", {131'b0, bus.enc_valid}, {131'b0, exp_valid});
      chk("sym_is_os", {131'b0, bus.sym_is_os}, {131'b0, exp_os});
      chk("lane_0_tx_enc", bus.lane_0_tx_enc, exp0);
      chk("lane_1_tx_enc", bus.lane_1_tx_enc, exp1);
    end
  end

  task automatic cyc(input bit en, input logic [1:0] g, input bit os, input logic [7:0] b);
    @(negedge enc_clk);
    bus.enable_enc = en;
    bus.gen_speed  = g;
    bus.data_os    = os;
    bus.lane_0_tx  = b;
    bus.lane_1_tx  = ~b;
    @(posedge enc_clk);
  endtask

  initial begin
    bus.enable_enc = 1'b0;
    bus.gen_speed  = 2'b10;
    bus.data_os    = 1'b0;
    bus.lane_0_tx  = '0;
    bus.lane_1_tx  = '0;
    rst = 1'b1;
    cyc(0, 2'b10, 0, 8'h00);
    cyc(0, 2'b10, 0, 8'h00);
    #1;
    chk("reset lane0", bus.lane_0_tx_enc, '0);
    chk("reset valid", {131'b0, bus.enc_valid}, '0);
    cmp_on = 1'b1;
    rst = 1'b0;

    // GEN2 data symbol 0x01..0x08
    for (int i = 1; i <= 8; i++) cyc(1, 2'b10, 0, 8'(i));
    #1;
    chk("gen2 valid", {131'b0, bus.enc_valid}, 132'd1);
    chk("gen2 hdr", {130'b0, bus.lane_0_tx_enc[1:0]}, {130'b0, 2'b01});
    chk("gen2 byte0", {124'b0, bus.lane_0_tx_enc[9:2]}, {124'b0, 8'h01});
    chk("gen2 byte7", {124'b0, bus.lane_0_tx_enc[65:58]}, {124'b0, 8'h08});
    chk("gen2 upper", {66'b0, bus.lane_0_tx_enc[131:66]}, '0);
    chk("gen2 full", bus.lane_0_tx_enc, {66'b0, 66'h201C1814100C0805});

    // Four back-to-back GEN3 ordered-set symbols
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 16; i++) cyc(1, 2'b01, 1, 8'(8'h10 + 16*s + i));
      #1;
      chk("gen3 b2b valid", {131'b0, bus.enc_valid}, 132'd1);
      if (s == 0) begin
        chk("gen3 hdr", {128'b0, bus.lane_0_tx_enc[3:0]}, {128'b0, 4'b1010});
        chk("gen3 byte15", {124'b0, bus.lane_0_tx_enc[131:124]}, {124'b0, 8'h1F});
        chk("gen3 byte0", {124'b0, bus.lane_0_tx_enc[11:4]}, {124'b0, 8'h10});
        chk("gen3 os", {131'b0, bus.sym_is_os}, 132'd1);
      end
    end

    // GEN4 raw block 0xA0..0xAF
    for (int i = 0; i < 16; i++) cyc(1, 2'b00, 0, 8'(8'hA0 + i));
    #1;
    chk("gen4 byte0", {124'b0, bus.lane_0_tx_enc[7:0]}, {124'b0, 8'hA0});
    chk("gen4 byte15", {124'b0, bus.lane_0_tx_enc[127:120]}, {124'b0, 8'hAF});
    chk("gen4 top", {128'b0, bus.lane_0_tx_enc[131:128]}, '0);
    cyc(0, 2'b00, 0, 8'h00);

    // Enable dropped after 5 GEN2 bytes, then a full symbol
    for (int i = 0; i < 5; i++) cyc(1, 2'b10, 0, 8'(8'h50 + i));
    cyc(0, 2'b10, 0, 8'h00);
    cyc(0, 2'b10, 0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1, 2'b10, 0, 8'(8'h30 + i));
    #1;
    chk("restart valid", {131'b0, bus.enc_valid}, 132'd1);
    chk("restart byte0", {124'b0, bus.lane_0_tx_enc[9:2]}, {124'b0, 8'h30});

    // gen_speed / data_os changed mid-symbol are ignored
    for (int i = 0; i < 8; i++)
      cyc(1, (i < 3) ? 2'b10 : 2'b01, i[0], 8'(8'h60 + i));
    #1;
    chk("midswitch hdr", {130'b0, bus.lane_0_tx_enc[1:0]}, {130'b0, 2'b01});
    chk("midswitch upper", {66'b0, bus.lane_0_tx_enc[131:66]}, '0);
    chk("midswitch os", {131'b0, bus.sym_is_os}, '0);
    for (int i = 0; i < 16; i++) cyc(1, 2'b01, 0, 8'(8'h70 + i));
    #1;
    chk("next gen3 hdr", {128'b0, bus.lane_0_tx_enc[3:0]}, {128'b0, 4'b0101});

    // Reset at byte 10 of a GEN3 symbol
    for (int i = 0; i < 10; i++) cyc(1, 2'b01, 0, 8'(8'h90 + i));
    rst = 1'b1;
    cyc(1, 2'b01, 0, 8'h9A);
    #1;
    chk("midrst lane0", bus.lane_0_tx_enc, '0);
    chk("midrst lane1", bus.lane_1_tx_enc, '0);
    chk("midrst valid", {131'b0, bus.enc_valid}, '0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1, 2'b10, 0, 8'(8'h80 + i));
    #1;
    chk("post-rst byte0", {124'b0, bus.lane_0_tx_enc[9:2]}, {124'b0, 8'h80});

    // Reserved generation behaves as disabled
    for (int i = 0; i < 20; i++) cyc(1, 2'b11, 0, 8'(8'hC0 + i));
    #1;
    chk("reserved valid", {131'b0, bus.enc_valid}, '0);
    chk("reserved hold", {124'b0, bus.lane_0_tx_enc[9:2]}, {124'b0, 8'h80});
    cyc(0, 2'b10, 0, 8'h00);
    cyc(0, 2'b10, 0, 8'h00);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
